// File: rtl/vga_pkg.sv
// Raster timing presets shared by the VGA timing generator and its users.
// Select a preset by overriding the generator's parameters with these fields.
package vga_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } vga_timing_t;

    // 640x480@60, 25 MHz pixel clock from a 50 MHz system clock.
    localparam vga_timing_t VGA_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
    };
    localparam int unsigned VGA_640X480_CLK_DIV = 2;

    // 800x600@60, 40 MHz pixel clock.
    localparam vga_timing_t SVGA_800X600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
    };

    // A divide-by-one prescaler still needs a one-bit register.
    function automatic int unsigned presc_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..TOTAL-1 on inc, resets to TOTAL-1 so the first
// increment lands on 0. cnt_next exposes the value the register is about to take.
module vga_axis_counter #(
    parameter int unsigned TOTAL = 800,
    parameter int unsigned W     = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic [W-1:0] cnt_next
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    always_comb begin
        wrap     = inc && (cnt == LAST);
        cnt_next = cnt;
        if (wrap) begin
            cnt_next = '0;
        end else if (inc) begin
            cnt_next = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= LAST;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: prescaler, H/V counters and registered
// sync/enable/strobe outputs, all aligned to the same (x,y).
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_640X480_60.h_active,
    parameter int unsigned H_FP     = VGA_640X480_60.h_fp,
    parameter int unsigned H_SYNC   = VGA_640X480_60.h_sync,
    parameter int unsigned H_BP     = VGA_640X480_60.h_bp,
    parameter int unsigned V_ACTIVE = VGA_640X480_60.v_active,
    parameter int unsigned V_FP     = VGA_640X480_60.v_fp,
    parameter int unsigned V_SYNC   = VGA_640X480_60.v_sync,
    parameter int unsigned V_BP     = VGA_640X480_60.v_bp,
    parameter int unsigned CLK_DIV  = VGA_640X480_CLK_DIV,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned CNT_W    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic             pix_tick,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             hs,
    output logic             vs,
    output logic             de,
    output logic             blank,
    output logic             line_start,
    output logic             frame_start,
    output logic             vblank_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned PW      = presc_width(CLK_DIV);

    localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [PW-1:0]    presc;
    logic             h_wrap;
    logic             v_wrap;
    logic [CNT_W-1:0] x_next;
    logic [CNT_W-1:0] y_next;
    logic             hs_on;
    logic             vs_on;
    logic             de_next;

    // Reset wins over a pending tick, so the strobe is gated here too.
    assign pix_tick = en && !reset && (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (en) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        end
    end

    vga_axis_counter #(
        .TOTAL (H_TOTAL),
        .W     (CNT_W)
    ) u_h_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (pix_tick),
        .cnt      (x),
        .wrap     (h_wrap),
        .cnt_next (x_next)
    );

    vga_axis_counter #(
        .TOTAL (V_TOTAL),
        .W     (CNT_W)
    ) u_v_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc      (h_wrap & pix_tick),
        .cnt      (y),
        .wrap     (v_wrap),
        .cnt_next (y_next)
    );

    // Decode from the values the counters take on this edge, so the registered
    // outputs describe the same pixel as x/y in the following cycle.
    always_comb begin
        hs_on   = (x_next >= HS_START) && (x_next < HS_END);
        vs_on   = (y_next >= VS_START) && (y_next < VS_END);
        de_next = (x_next < H_ACT) && (y_next < V_ACT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs           <= ~HS_POL;
            vs           <= ~VS_POL;
            de           <= 1'b0;
            blank        <= 1'b1;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            hs           <= hs_on ? HS_POL : ~HS_POL;
            vs           <= vs_on ? VS_POL : ~VS_POL;
            de           <= de_next;
            blank        <= ~de_next;
            line_start   <= h_wrap;
            frame_start  <= h_wrap & v_wrap;
            vblank_start <= h_wrap && (y_next == V_ACT);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, tiny, medium) checked against
// a tick-count position model plus a vector table and directed corner sequences.
module tb_vga_timing_gen;

    typedef struct { int x; int y; bit hs; bit vs; bit de; bit blank; bit ls; bit fs; bit vbs; } obs_t;
    typedef struct { int ha; int hf; int hsy; int hb; int va; int vf; int vsy; int vb; int div; bit hpol; bit vpol; } cfg_t;
    typedef struct { longint ecnt; bit fresh; } mdl_t;
    typedef struct { bit rst; bit en; int x; int y; bit hs; bit vs; bit de; bit ls; bit fs; } vec_t;

    int errors = 0;
    int checks = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       d_reset = 1'b1, d_en = 1'b0;
    logic       d_pix_tick, d_hs, d_vs, d_de, d_blank, d_ls, d_fs, d_vbs;
    logic [9:0] d_x, d_y;
    logic       t_reset = 1'b1, t_en = 1'b0;
    logic       t_pix_tick, t_hs, t_vs, t_de, t_blank, t_ls, t_fs, t_vbs;
    logic [2:0] t_x, t_y;
    logic       m_reset = 1'b1, m_en = 1'b0;
    logic       m_pix_tick, m_hs, m_vs, m_de, m_blank, m_ls, m_fs, m_vbs;
    logic [4:0] m_x, m_y;

    vga_timing_gen u_def (
        .clk(clk), .reset(d_reset), .en(d_en), .pix_tick(d_pix_tick), .x(d_x), .y(d_y),
        .hs(d_hs), .vs(d_vs), .de(d_de), .blank(d_blank), .line_start(d_ls),
        .frame_start(d_fs), .vblank_start(d_vbs)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .CLK_DIV(1), .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(3)
    ) u_tiny (
        .clk(clk), .reset(t_reset), .en(t_en), .pix_tick(t_pix_tick), .x(t_x), .y(t_y),
        .hs(t_hs), .vs(t_vs), .de(t_de), .blank(t_blank), .line_start(t_ls),
        .frame_start(t_fs), .vblank_start(t_vbs)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CLK_DIV(3), .HS_POL(1'b1), .VS_POL(1'b0), .CNT_W(5)
    ) u_med (
        .clk(clk), .reset(m_reset), .en(m_en), .pix_tick(m_pix_tick), .x(m_x), .y(m_y),
        .hs(m_hs), .vs(m_vs), .de(m_de), .blank(m_blank), .line_start(m_ls),
        .frame_start(m_fs), .vblank_start(m_vbs)
    );

    cfg_t  cfg[3];
    mdl_t  mdl[3];
    string nm[3];
    vec_t  tbl[13];

    // Position is a pure function of enabled cycles since reset: ticks = ecnt/div,
    // and tick 0 sits on the last pixel of the frame.
    function automatic obs_t expect_of(cfg_t c, mdl_t m);
        obs_t   e;
        longint ht  = c.ha + c.hf + c.hsy + c.hb;
        longint vt  = c.va + c.vf + c.vsy + c.vb;
        longint pos = (m.ecnt / c.div + ht * vt - 1) % (ht * vt);
        e.x     = int'(pos % ht);
        e.y     = int'(pos / ht);
        e.hs    = (e.x >= c.ha + c.hf && e.x < c.ha + c.hf + c.hsy) ? c.hpol : !c.hpol;
        e.vs    = (e.y >= c.va + c.vf && e.y < c.va + c.vf + c.vsy) ? c.vpol : !c.vpol;
        e.de    = (e.x < c.ha) && (e.y < c.va);
        e.blank = !e.de;
        e.ls    = m.fresh && (e.x == 0);
        e.fs    = e.ls && (e.y == 0);
        e.vbs   = e.ls && (e.y == c.va);
        return e;
    endfunction

    function automatic bit tick_of(cfg_t c, mdl_t m, bit rst, bit en);
        return en && !rst && (((m.ecnt + 1) % c.div) == 0);
    endfunction

    function automatic mdl_t step(cfg_t c, mdl_t m, bit rst, bit en);
        mdl_t n;
        n.ecnt  = rst ? 0 : (en ? m.ecnt + 1 : m.ecnt);
        n.fresh = !rst && en && ((n.ecnt % c.div) == 0);
        return n;
    endfunction

    function automatic obs_t obs_of(int which);
        obs_t o;
        case (which)
            0:       o = '{int'(d_x), int'(d_y), d_hs, d_vs, d_de, d_blank, d_ls, d_fs, d_vbs};
            1:       o = '{int'(t_x), int'(t_y), t_hs, t_vs, t_de, t_blank, t_ls, t_fs, t_vbs};
            default: o = '{int'(m_x), int'(m_y), m_hs, m_vs, m_de, m_blank, m_ls, m_fs, m_vbs};
        endcase
        return o;
    endfunction

    task automatic cmp(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
        cmp({tag, ".x"}, a.x, e.x);
        cmp({tag, ".y"}, a.y, e.y);
        cmp({tag, ".hs"}, longint'(a.hs), longint'(e.hs));
        cmp({tag, ".vs"}, longint'(a.vs), longint'(e.vs));
        cmp({tag, ".de"}, longint'(a.de), longint'(e.de));
        cmp({tag, ".blank"}, longint'(a.blank), longint'(e.blank));
        cmp({tag, ".line_start"}, longint'(a.ls), longint'(e.ls));
        cmp({tag, ".frame_start"}, longint'(a.fs), longint'(e.fs));
        cmp({tag, ".vblank_start"}, longint'(a.vbs), longint'(e.vbs));
    endtask

    // One clk cycle on one instance: drive, check pix_tick, clock, check all outputs.
    task automatic cyc(input int which, input bit rst, input bit en);
        logic pt;
        case (which)
            0:       begin d_reset = rst; d_en = en; end
            1:       begin t_reset = rst; t_en = en; end
            default: begin m_reset = rst; m_en = en; end
        endcase
        #1;
        pt = (which == 0) ? d_pix_tick : (which == 1) ? t_pix_tick : m_pix_tick;
        cmp({nm[which], ".pix_tick"}, longint'(pt), longint'(tick_of(cfg[which], mdl[which], rst, en)));
        @(posedge clk);
        #1;
        mdl[which] = step(cfg[which], mdl[which], rst, en);
        cmp_obs(nm[which], obs_of(which), expect_of(cfg[which], mdl[which]));
    endtask

    initial begin
        int last_fs, de_cnt, nfs, hs_cnt, hs_min, hs_max, steps;
        bit found;

        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0};
        cfg[1] = '{4, 1, 1, 1, 3, 1, 1, 1, 1, 1'b0, 1'b0};
        cfg[2] = '{16, 2, 3, 2, 10, 2, 2, 3, 3, 1'b1, 1'b0};
        nm[0] = "def"; nm[1] = "tiny"; nm[2] = "med";
        for (int unsigned i = 0; i < 3; i++) mdl[i] = '{0, 1'b0};

        //            rst   en    x  y  hs    vs    de    ls    fs
        tbl[0]  = '{1'b1, 1'b1, 6, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 2, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 3, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 4, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 6, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 0, 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 0, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 6, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        @(posedge clk);
        #1;

        // Tiny config: hand-derived vector table.
        for (int unsigned i = 0; i < 13; i++) begin
            t_reset = tbl[i].rst;
            t_en    = tbl[i].en;
            @(posedge clk);
            #1;
            cmp($sformatf("tbl%0d.x", i), int'(t_x), tbl[i].x);
            cmp($sformatf("tbl%0d.y", i), int'(t_y), tbl[i].y);
            cmp($sformatf("tbl%0d.hs", i), longint'(t_hs), longint'(tbl[i].hs));
            cmp($sformatf("tbl%0d.vs", i), longint'(t_vs), longint'(tbl[i].vs));
            cmp($sformatf("tbl%0d.de", i), longint'(t_de), longint'(tbl[i].de));
            cmp($sformatf("tbl%0d.blank", i), longint'(t_blank), longint'(!tbl[i].de));
            cmp($sformatf("tbl%0d.line_start", i), longint'(t_ls), longint'(tbl[i].ls));
            cmp($sformatf("tbl%0d.frame_start", i), longint'(t_fs), longint'(tbl[i].fs));
        end

        // Tiny config: frame period 42 clk with 12 active-pixel cycles per frame.
        cyc(1, 1'b1, 1'b1);
        last_fs = -1; de_cnt = 0; nfs = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1, 1'b0, 1'b1);
            if (t_fs) begin
                if (last_fs >= 0) begin
                    cmp("tiny.fs_period", i - last_fs, 42);
                    cmp("tiny.de_per_frame", de_cnt, 12);
                end
                last_fs = i; de_cnt = 0; nfs++;
            end
            if (t_de) de_cnt++;
        end
        cmp("tiny.fs_count", nfs, 3);
        for (int i = 0; i < 200; i++) cyc(1, 1'b0, $urandom_range(0, 9) < 7);

        // Default config: reset release, first tick on the 2nd clk.
        cyc(0, 1'b1, 1'b1);
        cyc(0, 1'b0, 1'b1);
        cmp("def.pre_tick_x", int'(d_x), 799);
        cyc(0, 1'b0, 1'b1);
        cmp("def.first_tick_x", int'(d_x), 0);
        cmp("def.first_tick_fs", longint'(d_fs), 1);

        // Default config: one full line, hs active only over x=656..751.
        hs_cnt = 0; hs_min = 9999; hs_max = -1;
        for (int i = 0; i < 1600; i++) begin
            cyc(0, 1'b0, 1'b1);
            if (!d_hs) begin
                hs_cnt++;
                if (int'(d_x) < hs_min) hs_min = int'(d_x);
                if (int'(d_x) > hs_max) hs_max = int'(d_x);
            end
        end
        cmp("def.hs_low_clks", hs_cnt, 192);
        cmp("def.hs_first_x", hs_min, 656);
        cmp("def.hs_last_x", hs_max, 751);
        cmp("def.line1_y", int'(d_y), 1);

        // Default config: freeze for 37 clk at x=100, resume continues the prescaler.
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            cyc(0, 1'b0, 1'b1);
            if (int'(d_x) == 100) found = 1'b1;
        end
        cmp("def.reach_x100", longint'(found), 1);
        for (int i = 0; i < 37; i++) cyc(0, 1'b0, 1'b0);
        cmp("def.hold_x", int'(d_x), 100);
        cmp("def.hold_hs", longint'(d_hs), 1);
        steps = 0;
        for (int i = 0; i < 5 && int'(d_x) == 100; i++) begin
            cyc(0, 1'b0, 1'b1);
            steps++;
        end
        cmp("def.resume_x", int'(d_x), 101);
        cmp("def.resume_clks", steps, 2);

        // Medium config: randomized enable and occasional reset.
        cyc(2, 1'b1, 1'b0);
        for (int i = 0; i < 2500; i++) cyc(2, $urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0);

        // Medium config: reset mid-frame at (20,12) restores the reset state.
        cyc(2, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 1300 && !found; i++) begin
            cyc(2, 1'b0, 1'b1);
            if (int'(m_x) == 20 && int'(m_y) == 12) found = 1'b1;
        end
        cmp("med.reach_20_12", longint'(found), 1);
        cyc(2, 1'b1, 1'b1);
        cmp("med.rst_x", int'(m_x), 22);
        cmp("med.rst_y", int'(m_y), 16);
        cmp("med.rst_hs", longint'(m_hs), 0);
        cmp("med.rst_vs", longint'(m_vs), 1);
        cmp("med.rst_blank", longint'(m_blank), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
